// File: rtl/symbol_frame_pkg.sv
// rtl/symbol_frame_pkg.sv - shared symbol width, framing FSM states and FIFO entry layout
package symbol_frame_pkg;

    localparam int SYM_W = 7;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    typedef struct packed {
        logic [SYM_W-1:0] data;
        logic             sop;
        logic             eop;
        logic             err;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO; rd_data always presents the head entry
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    // Writes are refused while full even if a pop lands in the same cycle.
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/symbol_frame_check.sv
// rtl/symbol_frame_check.sv - packet framing/XOR/length checker with FIFO; optional counters via SYMBOL_FRAME_CHECK_STATS_EN
module symbol_frame_check
    import symbol_frame_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int MAX_LEN = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [SYM_W-1:0] data_in,
    input  logic             sop_in,
    input  logic             eop_in,
    output logic             ready_out,
    output logic             valid_out,
    output logic [SYM_W-1:0] data_out,
    output logic             sop_out,
    output logic             eop_out,
    output logic             err_out,
    input  logic             ready_in
`ifdef SYMBOL_FRAME_CHECK_STATS_EN
    ,
    output logic [15:0]      pkt_cnt_out,
    output logic [15:0]      err_cnt_out,
    output logic [15:0]      drop_cnt_out
`endif
);

    localparam int LEN_W = $clog2(MAX_LEN + 2);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    state_t           state_q;
    logic [SYM_W-1:0] csum_q, csum_new;
    logic [LEN_W-1:0] len_q, len_new;
    logic             frm_q, frm_new;
    logic             err_new;
    logic             accept;
    logic             wr_en;
    logic             rd_en;
    logic             full;
    logic             empty;
    entry_t           wr_entry;
    entry_t           rd_entry;

    assign accept = valid_in & ready_out;

    // Running packet state after absorbing data_in; a sop restarts it, and a sop seen mid-packet marks framing.
    always_comb begin
        csum_new = csum_q ^ data_in;
        len_new  = (len_q == LEN_SAT) ? len_q : len_q + 1'b1;
        frm_new  = frm_q;
        if (state_q == IDLE || sop_in) begin
            csum_new = data_in;
            len_new  = LEN_W'(1);
            frm_new  = (state_q == IN_PKT);
        end
        err_new  = (csum_new != '0) | (len_new > LEN_MAX) | frm_new;
        wr_en    = accept & ((state_q == IN_PKT) | sop_in);
        wr_entry = '{data: data_in, sop: sop_in, eop: eop_in, err: eop_in & err_new};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            csum_q  <= '0;
            len_q   <= '0;
            frm_q   <= 1'b0;
        end else if (wr_en) begin
            csum_q  <= csum_new;
            len_q   <= len_new;
            frm_q   <= frm_new;
            state_q <= eop_in ? IDLE : IN_PKT;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_entry),
        .rd_en   (rd_en),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty)
    );

    assign ready_out = ~full;
    assign valid_out = ~empty;
    assign rd_en     = valid_out & ready_in;
    assign data_out  = valid_out ? rd_entry.data : '0;
    assign sop_out   = valid_out & rd_entry.sop;
    assign eop_out   = valid_out & rd_entry.eop;
    assign err_out   = valid_out & rd_entry.eop & rd_entry.err;

`ifdef SYMBOL_FRAME_CHECK_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_out  <= '0;
            err_cnt_out  <= '0;
            drop_cnt_out <= '0;
        end else begin
            if (wr_en && eop_in && pkt_cnt_out != 16'hFFFF)
                pkt_cnt_out <= pkt_cnt_out + 1'b1;
            if (wr_en && eop_in && err_new && err_cnt_out != 16'hFFFF)
                err_cnt_out <= err_cnt_out + 1'b1;
            if (accept && state_q == IDLE && !sop_in && drop_cnt_out != 16'hFFFF)
                drop_cnt_out <= drop_cnt_out + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_symbol_frame_check.sv
// tb/tb_symbol_frame_check.sv - directed self-checking bench for symbol_frame_check (MAX_LEN=4)
module tb_symbol_frame_check;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic [6:0] data_in = '0;
    logic       sop_in = 1'b0;
    logic       eop_in = 1'b0;
    logic       ready_out;
    logic       valid_out;
    logic [6:0] data_out;
    logic       sop_out;
    logic       eop_out;
    logic       err_out;
    logic       ready_in = 1'b1;
`ifdef SYMBOL_FRAME_CHECK_STATS_EN
    logic [15:0] pkt_cnt_out;
    logic [15:0] err_cnt_out;
    logic [15:0] drop_cnt_out;
`endif

    int n_checks = 0;
    int n_err    = 0;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    symbol_frame_check #(.DEPTH(16), .MAX_LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .sop_in    (sop_in),
        .eop_in    (eop_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .sop_out   (sop_out),
        .eop_out   (eop_out),
        .err_out   (err_out),
        .ready_in  (ready_in)
`ifdef SYMBOL_FRAME_CHECK_STATS_EN
        ,
        .pkt_cnt_out  (pkt_cnt_out),
        .err_cnt_out  (err_cnt_out),
        .drop_cnt_out (drop_cnt_out)
`endif
    );

    always @(negedge clk) begin
        if (!rst && valid_out && ready_in)
            got_q.push_back({data_out, sop_out, eop_out, err_out});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] ent(input logic [6:0] d, input logic s, input logic e, input logic r);
        return {d, s, e, r};
    endfunction

    task automatic send(input logic [6:0] d, input logic s, input logic e);
        int n = 0;
        valid_in = 1'b1;
        data_in  = d;
        sop_in   = s;
        eop_in   = e;
        @(negedge clk);
        while (!ready_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready_out) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        sop_in   = 1'b0;
        eop_in   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        ready_in = 1'b1;
        @(negedge clk);
        while (valid_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (valid_out) chk("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string name);
        int n;
        chk($sformatf("%s_count", name), got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_sym%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready_out", ready_out, 1);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_flags", {sop_out, eop_out, err_out}, 0);

        // Clean 3-symbol packet, one-cycle latency.
        ready_in = 1'b1;
        send(7'h11, 1, 0);
        chk("lat_valid", valid_out, 1);
        chk("lat_data", data_out, 7'h11);
        send(7'h22, 0, 0);
        send(7'h33, 0, 1);
        drain();
        exp_q = '{ent(7'h11, 1, 0, 0), ent(7'h22, 0, 0, 0), ent(7'h33, 0, 1, 0)};
        compare("clean");

        // Bad checksum.
        send(7'h11, 1, 0);
        send(7'h22, 0, 0);
        send(7'h34, 0, 1);
        drain();
        exp_q = '{ent(7'h11, 1, 0, 0), ent(7'h22, 0, 0, 0), ent(7'h34, 0, 1, 1)};
        compare("csum");
`ifdef SYMBOL_FRAME_CHECK_STATS_EN
        chk("err_cnt", err_cnt_out, 1);
        chk("pkt_cnt", pkt_cnt_out, 2);
`endif

        // Stray symbol outside a packet is dropped.
        send(7'h05, 0, 0);
        @(negedge clk);
        chk("drop_valid", valid_out, 0);
        drain();
        compare("drop");
`ifdef SYMBOL_FRAME_CHECK_STATS_EN
        chk("drop_cnt", drop_cnt_out, 1);
`endif

        // Length boundary at MAX_LEN=4: 4 ok, 5 and 6 flagged (all XOR to zero).
        send(7'h01, 1, 0); send(7'h02, 0, 0); send(7'h04, 0, 0); send(7'h07, 0, 1);
        send(7'h01, 1, 0); send(7'h02, 0, 0); send(7'h04, 0, 0); send(7'h08, 0, 0);
        send(7'h0F, 0, 1);
        send(7'h01, 1, 0); send(7'h02, 0, 0); send(7'h04, 0, 0); send(7'h08, 0, 0);
        send(7'h10, 0, 0); send(7'h1F, 0, 1);
        drain();
        exp_q = '{ent(7'h01, 1, 0, 0), ent(7'h02, 0, 0, 0), ent(7'h04, 0, 0, 0), ent(7'h07, 0, 1, 0),
                  ent(7'h01, 1, 0, 0), ent(7'h02, 0, 0, 0), ent(7'h04, 0, 0, 0), ent(7'h08, 0, 0, 0),
                  ent(7'h0F, 0, 1, 1),
                  ent(7'h01, 1, 0, 0), ent(7'h02, 0, 0, 0), ent(7'h04, 0, 0, 0), ent(7'h08, 0, 0, 0),
                  ent(7'h10, 0, 0, 0), ent(7'h1F, 0, 1, 1)};
        compare("len");

        // Sop inside a packet: framing error even though the restarted XOR is zero.
        send(7'h11, 1, 0);
        send(7'h22, 0, 0);
        send(7'h33, 1, 0);
        send(7'h33, 0, 1);
        drain();
        exp_q = '{ent(7'h11, 1, 0, 0), ent(7'h22, 0, 0, 0), ent(7'h33, 1, 0, 0), ent(7'h33, 0, 1, 1)};
        compare("frame");

        // Fill to full with single-symbol packets, 17th refused, then drain in order.
        ready_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send(7'(i), 1, 1);
            exp_q.push_back(ent(7'(i), 1, 1, i != 0));
        end
        chk("full_ready_out", ready_out, 0);
        valid_in = 1'b1; data_in = 7'h7F; sop_in = 1'b1; eop_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("full_hold_ready", ready_out, 0);
        valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
        drain();
        compare("fill");

        // Reset mid-packet discards buffered symbols.
        ready_in = 1'b0;
        send(7'h11, 1, 0);
        send(7'h22, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_valid", valid_out, 0);
        chk("midrst_eop", eop_out, 0);
        chk("midrst_ready", ready_out, 1);
`ifdef SYMBOL_FRAME_CHECK_STATS_EN
        chk("midrst_pkt_cnt", pkt_cnt_out, 0);
`endif
        ready_in = 1'b1;
        send(7'h33, 0, 1);
        send(7'h11, 1, 0);
        send(7'h22, 0, 0);
        send(7'h33, 0, 1);
        drain();
        exp_q = '{ent(7'h11, 1, 0, 0), ent(7'h22, 0, 0, 0), ent(7'h33, 0, 1, 0)};
        compare("after_rst");
`ifdef SYMBOL_FRAME_CHECK_STATS_EN
        chk("after_rst_pkt_cnt", pkt_cnt_out, 1);
        chk("after_rst_drop_cnt", drop_cnt_out, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
